mar_burst_seq: RTL and testbench

Parametrised memory address register with a built-in burst address sequencer. It holds a base address and, on command, issues a sequence of addresses to the memory port over a valid/ready handshake. Sequences can be linear or wrapping, and up to 2^LW beats long. It sits between the processor control unit, which loads and starts it, and the memory interface, which consumes addresses. The remembered address always reflects the next un-issued address.

---
 rtl/mar_burst_seq.sv | 128 ++++++++++++
 tb/tb_mar_burst_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mar_burst_seq.sv
// Memory address register with a linear/wrapping burst address sequencer.
// Issues len_in+1 beat addresses over a valid/ready handshake; MAR tracks the next un-issued address.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no burst; addr_out mirrors MAR; ld and start honoured
// S_BURST | beat addresses presented on addr_out with addr_valid high
module mar_burst_seq #(
  parameter int AW   = 13,
  parameter int LW   = 4,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [AW-1:0] addr_in,
  input  logic          start,
  input  logic [LW-1:0] len_in,
  input  logic          mode_in,
  input  logic          abort,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW-1:0] nxt_addr;
  logic [AW-1:0] base_addr;

  // Wrap mode holds the upper bits and rolls only the low LW bits.
  always_comb begin
    if (mode_q) begin
      nxt_addr = {addr_q[AW-1:LW], addr_q[LW-1:0] + LW'(1)};
    end else begin
      nxt_addr = addr_q + AW'(STEP);
    end
  end

  assign base_addr = ld ? addr_in : mar_q;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          cnt_d   = len_in;
          mode_d  = mode_in;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_BURST;
        end else if (ld) begin
          mar_d  = addr_in;
          addr_d = addr_in;
        end
      end
      S_BURST: begin
        // Abort wins over a same-cycle handshake: the presented beat is left un-issued.
        if (abort) begin
          mar_d   = addr_q;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (valid_q && addr_ready) begin
          if (cnt_q != '0) begin
            addr_d = nxt_addr;
            cnt_d  = cnt_q - LW'(1);
          end else begin
            mar_d   = nxt_addr;
            addr_d  = nxt_addr;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mar_burst_seq.sv
// Bench for mar_burst_seq: directed scenarios plus random traffic against a beat-list model.
module tb_mar_burst_seq;
  localparam int AW   = 13;
  localparam int LW   = 4;
  localparam int STEP = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld;
  logic [AW-1:0] addr_in;
  logic          start;
  logic [LW-1:0] len_in;
  logic          mode_in;
  logic          abort;
  logic [AW-1:0] addr_out;
  logic          addr_valid;
  logic          addr_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Model: when busy, m_q holds the remaining beat addresses followed by the
  // address MAR takes on completion.
  bit            m_busy;
  bit            m_done;
  logic [AW-1:0] m_mar;
  logic [AW-1:0] m_q[$];

  always #5 clk = ~clk;

  mar_burst_seq #(.AW(AW), .LW(LW), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .ld(ld), .addr_in(addr_in), .start(start),
    .len_in(len_in), .mode_in(mode_in), .abort(abort), .addr_out(addr_out),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input int k, input bit mode);
    int unsigned b, mask, kk;
    b    = base;
    kk   = k;
    mask = (32'd1 << LW) - 1;
    if (!mode) return AW'(b + kk * STEP);
    return AW'((b & ~mask) | ((b + kk) & mask));
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_done = 0;
    m_mar  = '0;
    m_q.delete();
  endtask

  task automatic model_edge();
    logic [AW-1:0] base;
    m_done = 0;
    if (!m_busy) begin
      if (start) begin
        base = ld ? addr_in : m_mar;
        m_q.delete();
        for (int k = 0; k <= int'(len_in) + 1; k++) m_q.push_back(beat_addr(base, k, mode_in));
        m_busy = 1;
      end else if (ld) begin
        m_mar = addr_in;
      end
    end else if (abort) begin
      m_mar  = m_q[0];
      m_busy = 0;
      m_q.delete();
    end else if (addr_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 1) begin
        m_mar  = m_q[0];
        m_busy = 0;
        m_done = 1;
        m_q.delete();
      end
    end
  endtask

  task automatic check_model();
    chk("addr_out", 32'(addr_out), 32'(m_busy ? m_q[0] : m_mar));
    chk("addr_valid", 32'(addr_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic quiet();
    ld = 0; start = 0; abort = 0; addr_ready = 1;
    addr_in = '0; len_in = '0; mode_in = 0;
  endtask

  task automatic async_reset();
    rst = 0;
    #1;
    model_reset();
    chk("rst_addr_out", 32'(addr_out), 32'h0);
    chk("rst_valid", 32'(addr_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    #1;
    rst = 1;
  endtask

  logic [AW-1:0] exp_seq[4];

  initial begin
    quiet();
    model_reset();
    rst = 0;
    #2;
    chk("por_addr_out", 32'(addr_out), 32'h0);
    chk("por_busy", 32'(busy), 32'h0);
    #5;
    rst = 1;

    ld = 1; addr_in = 13'h0123;
    step();
    chk("ld_0123", 32'(addr_out), 32'h0123);
    quiet();
    step();

    // Linear burst rolling over the top of the address space.
    ld = 1; start = 1; addr_in = 13'h1FFE; len_in = 3; mode_in = 0;
    exp_seq = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    step();
    quiet();
    for (int i = 0; i < 4; i++) begin
      chk("lin_beat", 32'(addr_out), 32'(exp_seq[i]));
      step();
    end
    chk("lin_done", 32'(done), 32'h1);
    chk("lin_final", 32'(addr_out), 32'h0002);
    step();
    chk("lin_done_drop", 32'(done), 32'h0);

    // Wrapping burst on a 16-beat boundary.
    ld = 1; start = 1; addr_in = 13'h003E; len_in = 3; mode_in = 1;
    exp_seq = '{13'h003E, 13'h003F, 13'h0030, 13'h0031};
    step();
    quiet();
    for (int i = 0; i < 4; i++) begin
      chk("wrap_beat", 32'(addr_out), 32'(exp_seq[i]));
      step();
    end
    chk("wrap_done", 32'(done), 32'h1);
    chk("wrap_final", 32'(addr_out), 32'h0032);
    step();

    // Backpressure on beat 0 for three cycles.
    ld = 1; start = 1; addr_in = 13'h0100; len_in = 1; mode_in = 0;
    step();
    quiet();
    addr_ready = 0;
    chk("bp_hold0", 32'(addr_out), 32'h0100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", 32'(addr_out), 32'h0100);
      chk("bp_valid", 32'(addr_valid), 32'h1);
    end
    addr_ready = 1;
    step();
    chk("bp_beat1", 32'(addr_out), 32'h0101);
    step();
    chk("bp_done", 32'(done), 32'h1);
    step();

    // Abort on beat 2 with a load attempted during beat 1.
    ld = 1; start = 1; addr_in = 13'h0200; len_in = 7; mode_in = 0;
    step();
    quiet();
    step();
    chk("ab_beat1", 32'(addr_out), 32'h0201);
    ld = 1; addr_in = 13'h1555;
    step();
    chk("ab_beat2", 32'(addr_out), 32'h0202);
    ld = 0; abort = 1;
    step();
    abort = 0;
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_nodone", 32'(done), 32'h0);
    chk("ab_mar", 32'(addr_out), 32'h0202);
    start = 1; len_in = 0;
    step();
    start = 0;
    chk("ab_resume", 32'(addr_out), 32'h0202);
    step();
    step();

    // Same-cycle ld+start, then a start issued in the done cycle.
    ld = 1; start = 1; addr_in = 13'h0040; len_in = 0; mode_in = 0;
    step();
    quiet();
    chk("ls_beat", 32'(addr_out), 32'h0040);
    step();
    chk("ls_done", 32'(done), 32'h1);
    chk("ls_mar", 32'(addr_out), 32'h0041);
    start = 1;
    step();
    start = 0;
    chk("ls_restart_valid", 32'(addr_valid), 32'h1);
    chk("ls_restart_addr", 32'(addr_out), 32'h0041);
    step();
    chk("ls_restart_done", 32'(done), 32'h1);
    chk("ls_restart_mar", 32'(addr_out), 32'h0042);

    // Asynchronous reset in the middle of a burst.
    ld = 1; start = 1; addr_in = 13'h0ABC; len_in = 5; mode_in = 0;
    step();
    quiet();
    step();
    #2;
    async_reset();
    step();
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      ld         = ($urandom_range(0, 3) == 0);
      start      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 11) == 0);
      addr_ready = ($urandom_range(0, 9) < 7);
      addr_in    = AW'($urandom);
      len_in     = LW'($urandom);
      mode_in    = 1'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
